// File: rtl/trace_capture.sv
// Passive trace recorder beside the single-cycle processor: snapshots register-write and
// store events with a cycle timestamp into a first-word-fall-through FIFO for a downstream reader.
module trace_capture #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TS_W        = 16,
  parameter bit          CAPTURE_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              flush,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              rf_wr,
  input  logic [4:0]        rw,
  input  logic [31:0]       dw,
  input  logic              dm_wr,
  input  logic [31:0]       alu_output,
  input  logic [31:0]       crt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_data,
  output logic [31:0]       out_aux,
  output logic [TS_W-1:0]   out_ts,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);

  // Reader handshake: the head entry transfers on any rising edge where out_valid and
  // out_ready are both 1 (and flush is 0). out_valid never depends on out_ready, and
  // out_ready is ignored while the FIFO is empty.

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [31:0]     mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [31:0]     mem_aux  [DEPTH];
  logic [TS_W-1:0] mem_ts   [DEPTH];
  logic [1:0]      mem_kind [DEPTH];

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0]   ts;
  logic [ADDR_W:0]   level_nxt;

  logic        push_req, push_ok, pop, full, drop;
  logic [1:0]  in_kind;
  logic [31:0] in_data, in_aux;

  assign full     = (level == FULL_LEVEL);
  assign push_req = cap_en & ~flush & (rf_wr | dm_wr | CAPTURE_ALL);
  assign pop      = out_valid & out_ready & ~flush;
  // At full a simultaneous pop frees the head slot, which is the slot being written.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign in_kind = {dm_wr, rf_wr};

  always_comb begin
    in_data = '0;
    in_aux  = '0;
    if (rf_wr)      in_data = dw;
    else if (dm_wr) in_data = crt;
    if (dm_wr)      in_aux = alu_output;
    else if (rf_wr) in_aux = {27'b0, rw};
  end

  always_comb begin
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + (ADDR_W+1)'(1);
      2'b01:   level_nxt = level - (ADDR_W+1)'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
        level <= level_nxt;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  // Entry storage carries no reset; empty-state outputs are masked below instead.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr]   <= pc;
      mem_inst[wr_ptr] <= inst;
      mem_data[wr_ptr] <= in_data;
      mem_aux[wr_ptr]  <= in_aux;
      mem_ts[wr_ptr]   <= ts;
      mem_kind[wr_ptr] <= in_kind;
    end
  end

  assign out_valid = (level != '0);
  assign out_kind  = out_valid ? mem_kind[rd_ptr] : '0;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_inst  = out_valid ? mem_inst[rd_ptr] : '0;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_aux   = out_valid ? mem_aux[rd_ptr]  : '0;
  assign out_ts    = out_valid ? mem_ts[rd_ptr]   : '0;

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Passive observer on the single-cycle processor's debug outputs; the consuming end of the signals the processor exports per instruction.
- Each clock, records architecturally visible events (register write, store) into a FIFO with a cycle timestamp.
- A downstream reader (bench monitor or UART dumper) drains entries over a valid/ready handshake.
- Sits beside the processor top, clocked by the same clk; never drives the processor.

Parameters:
DEPTH, 16, FIFO entries; power of two, >=2
ADDR_W, 4, log2(DEPTH)
TS_W, 16, timestamp counter width
CAPTURE_ALL, 0, 1 = also record instructions with neither rf_wr nor dm_wr

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cap_en  in  1  capture enable
flush  in  1  synchronous FIFO clear
pc  in  32  PC of the instruction executing this cycle
inst  in  32  instruction word
rf_wr  in  1  register-file write strobe
rw  in  5  destination register
dw  in  32  register write data
dm_wr  in  1  data-memory write strobe
alu_output  in  32  store address
crt  in  32  store data
out_valid  out  1  head entry available
out_ready  in  1  reader accepts head entry
out_kind  out  2  00 other, 01 reg write, 10 store, 11 both
out_pc  out  32  entry PC
out_inst  out  32  entry instruction
out_data  out  32  dw (01, 11) or crt (10); 0 for kind 00
out_aux  out  32  {27'b0,rw} (01), alu_output (10, 11); 0 for kind 00
out_ts  out  TS_W  timestamp at capture
level  out  ADDR_W+1  entries held, 0..DEPTH
drop_cnt  out  16  entries lost to full FIFO, saturates at 16'hFFFF
overflow  out  1  sticky: set on any drop, cleared only by flush or reset

Behaviour:
- Reset (async, rst_n=0): pointers, level, ts, drop_cnt, overflow = 0; out_valid = 0; all out_* fields = 0. Reset mid-stream discards all stored entries.
- ts: free-running, +1 every clock, wraps to 0 after all-ones.
- Push request = cap_en & ~flush & (rf_wr | dm_wr | CAPTURE_ALL). Kind derived from {dm_wr, rf_wr}. Snapshot of inputs and current ts written at the rising edge.
- Pop = out_valid & out_ready.
- FIFO is first-word-fall-through:
  - out_* show the head entry combinationally from storage.
  - All out_* fields are forced to 0 when level = 0.
- out_valid = (level != 0).
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N. No same-cycle bypass from inputs to outputs.
- Full (level = DEPTH):
  - Push without pop: dropped; drop_cnt +1 (saturating); overflow set.
  - Push with pop in the same cycle: accepted; level stays DEPTH; no drop.
- Empty (level = 0): out_ready ignored; no pop occurs. A push still succeeds.
- Push and pop together, 0 < level < DEPTH: level unchanged.
- Pointers wrap modulo DEPTH.
- flush=1:
  - Next edge: pointers and level = 0; drop_cnt and overflow cleared.
  - Any push or pop in that cycle is ignored.
  - ts is not affected.
- Inputs are sampled only; the block imposes no timing on the processor.

Test Plan:
- Reset then idle 5 cycles with cap_en=1, rf_wr=dm_wr=0, CAPTURE_ALL=0 -> out_valid=0, level=0, all out_* = 0; ts=5 after 5 edges.
- Push one event: rf_wr=1, pc=32'h4, inst=32'h20080005, rw=8, dw=5, out_ready=0 -> next cycle out_valid=1, kind=01, out_aux=32'h8, out_data=5, out_ts equals the ts value at the push edge.
- Push one event: dm_wr=1, alu_output=32'h10, crt=32'hDEADBEEF -> entry kind=10, out_aux=32'h10, out_data=32'hDEADBEEF.
- Fill 16 entries with out_ready=0, then push 3 more -> level=16, drop_cnt=3, overflow=1. Then drain with out_ready=1 -> 16 entries appear in push order (pc 0,4,...,60), then out_valid=0.
- At level=16, push with out_ready=1 for 10 cycles -> level stays 16, drop_cnt unchanged, ordering preserved.
- With level=5 and overflow=1: assert flush together with a push -> level=0, drop_cnt=0, overflow=0, pushed entry absent. Separately, assert rst_n=0 mid-drain -> outputs 0 immediately, without waiting for a clock edge.
